// File: rtl/seg_scan_ctrl_pkg.sv
// rtl/seg_scan_ctrl_pkg.sv - shared segment patterns and constants for the scan controller
// Purpose: a..g segment codes (active-high, bit 6 = a ... bit 0 = g),
//          blank pattern, dp bit position in the 8-bit bus, anode-off value.
// Ports:   none (package)
package seg_scan_ctrl_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Bit of the 8-bit segment bus that carries the decimal point.
  localparam int DP_BIT = 0;

  // Widest supported anode bank, all anodes released (active-low).
  localparam logic [7:0] ANODE_OFF = 8'hFF;

endpackage

// File: rtl/seg_bcd_decode.sv
// rtl/seg_bcd_decode.sv - combinational BCD to seven-segment (a..g) decoder
// Purpose: maps a 4-bit BCD code to active-high a..g; codes 10..15 are dark.
// Ports:   bcd  [3:0] in  - BCD digit
//          seg7 [6:0] out - {a,b,c,d,e,f,g}
module seg_bcd_decode
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg7
);

  always_comb begin
    seg7 = SEG_BLANK;
    case (bcd)
      4'd0:    seg7 = SEG_0;
      4'd1:    seg7 = SEG_1;
      4'd2:    seg7 = SEG_2;
      4'd3:    seg7 = SEG_3;
      4'd4:    seg7 = SEG_4;
      4'd5:    seg7 = SEG_5;
      4'd6:    seg7 = SEG_6;
      4'd7:    seg7 = SEG_7;
      4'd8:    seg7 = SEG_8;
      4'd9:    seg7 = SEG_9;
      default: seg7 = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - time-multiplexed scan controller for common-anode 7-segment digits
// Purpose: holds a shadow and an active BCD+dp frame, scans one digit per
//          REFRESH_DIV-cycle slot with BLANK_CYC anti-ghost blanking, and
//          swaps the active frame only at frame boundaries (no tearing).
// Optional: LEADING_ZERO_BLANK_EN - dark leading zeros (digit 0 always shown).
// Ports:   clk, rst_n (async active-low)  - clock / reset
//          en                             - scan enable
//          wr_en, din, dp_in              - frame write (digit i = din[4i+3:4i])
//          seg [7:0]                      - {a..g,dp} active-high, registered
//          an  [NUM_DIGITS-1:0]           - one-cold anode select, registered
//          frame_done                     - pulse after each frame boundary
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int BLANK_CYC   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    wr_en,
  input  logic [4*NUM_DIGITS-1:0] din,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] sh_dig;
  logic [4*NUM_DIGITS-1:0] act_dig;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   act_dp;

  logic                    cnt_last;
  logic                    idx_last;
  logic                    boundary;
  logic                    in_blank;
  logic [3:0]              cur_dig;
  logic                    cur_dp;
  logic [6:0]              dec7;
  logic                    suppress;
  logic [7:0]              seg_next;
  logic [NUM_DIGITS-1:0]   an_next;

  assign cnt_last = (cnt == CNT_W'(REFRESH_DIV - 1));
  assign idx_last = (idx == IDX_W'(NUM_DIGITS - 1));
  assign boundary = en & cnt_last & idx_last;
  assign in_blank = (cnt < CNT_W'(BLANK_CYC));

  assign cur_dig = act_dig[{idx, 2'b00} +: 4];
  assign cur_dp  = act_dp[idx];

  seg_bcd_decode u_dec (
    .bcd  (cur_dig),
    .seg7 (dec7)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // lead_zero[i]: digit i and every more-significant digit are zero.
  logic [NUM_DIGITS-1:0] lead_zero;
  always_comb begin
    logic run;
    run       = 1'b1;
    lead_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run          = run & (act_dig[4*i +: 4] == 4'd0);
      lead_zero[i] = run;
    end
  end
  assign suppress = lead_zero[idx] & (idx != '0);
`else
  assign suppress = 1'b0;
`endif

  always_comb begin
    seg_next         = '0;
    seg_next[7:1]    = suppress ? SEG_BLANK : dec7;
    seg_next[DP_BIT] = cur_dp;
    an_next          = ANODE_OFF[NUM_DIGITS-1:0] & ~(NUM_DIGITS'(1) << idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      sh_dig     <= '0;
      sh_dp      <= '0;
      act_dig    <= '0;
      act_dp     <= '0;
      seg        <= '0;
      an         <= ANODE_OFF[NUM_DIGITS-1:0];
      frame_done <= 1'b0;
    end else begin
      if (wr_en) begin
        sh_dig <= din;
        sh_dp  <= dp_in;
      end
      // A write coinciding with the boundary bypasses the shadow so the
      // newest frame is the one that goes live.
      if (boundary) begin
        act_dig <= wr_en ? din   : sh_dig;
        act_dp  <= wr_en ? dp_in : sh_dp;
      end
      if (en) begin
        cnt <= cnt_last ? '0 : cnt + CNT_W'(1);
        if (cnt_last) begin
          idx <= idx_last ? '0 : idx + IDX_W'(1);
        end
      end
      frame_done <= boundary;
      if (!en || in_blank) begin
        seg <= '0;
        an  <= ANODE_OFF[NUM_DIGITS-1:0];
      end else begin
        seg <= seg_next;
        an  <= an_next;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - scoreboard bench for seg_scan_ctrl with a time-based reference model
module tb_seg_scan_ctrl;

  localparam int N     = 4;
  localparam int DIV   = 8;
  localparam int BLK   = 1;
  localparam int FRAME = N * DIV;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          wr_en;
  logic [4*N-1:0] din;
  logic [N-1:0]  dp_in;
  logic [7:0]    seg;
  logic [N-1:0]  an;
  logic          frame_done;

  seg_scan_ctrl #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (DIV),
    .BLANK_CYC   (BLK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .wr_en      (wr_en),
    .din        (din),
    .dp_in      (dp_in),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]   seg;
    logic [N-1:0] an;
    logic         fd;
  } exp_t;

  exp_t q[$];
  int   vecs = 0;
  int   errs = 0;

  // Reference state: t counts enabled cycles since reset; slot position and
  // digit index are derived from it arithmetically.
  int          t;
  logic [15:0] sh_d, ac_d;
  logic [3:0]  sh_p, ac_p;

  logic [6:0] dec_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b0000000, 7'b0000000,
    7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000
  };

  function automatic logic [6:0] shown(input int pos);
    logic [3:0] d;
    d = 4'((ac_d >> (4 * pos)) & 16'hF);
`ifdef LEADING_ZERO_BLANK_EN
    if (pos > 0 && (ac_d >> (4 * pos)) == 16'h0) return 7'b0000000;
`endif
    return dec_tab[d];
  endfunction

  // Reference model: predicts what the DUT shows after each rising edge.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      t    = 0;
      sh_d = '0; sh_p = '0;
      ac_d = '0; ac_p = '0;
      q.delete();
    end else begin
      int   pos, slot_cyc;
      logic fd;
      exp_t e;
      slot_cyc = t % DIV;
      pos      = (t / DIV) % N;
      fd       = en && (t % FRAME) == FRAME - 1;
      e.seg    = 8'h00;
      e.an     = '1;
      e.fd     = fd;
      if (en && slot_cyc >= BLK) begin
        e.an[pos] = 1'b0;
        e.seg     = {shown(pos), ac_p[pos]};
      end
      q.push_back(e);
      if (fd) begin
        ac_d = wr_en ? din   : sh_d;
        ac_p = wr_en ? dp_in : sh_p;
      end
      if (wr_en) begin
        sh_d = din;
        sh_p = dp_in;
      end
      if (en) t++;
    end
  end

  // Monitor: every cycle the DUT presents a registered output word.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      vecs++;
      if ({seg, an, frame_done} !== e) begin
        errs++;
        $display("FAIL scan @%0t: got seg=%h an=%b fd=%b, want seg=%h an=%b fd=%b",
                 $time, seg, an, frame_done, e.seg, e.an, e.fd);
      end
      vecs++;
      if ($countones(~an) > 1) begin
        errs++;
        $display("FAIL one_cold @%0t: an=%b, want at most one low bit", $time, an);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write(input logic [15:0] d, input logic [3:0] p);
    wr_en = 1'b1; din = d; dp_in = p;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Park at a negedge where the next rising edge sees frame position p.
  task automatic wait_phase(input int p);
    int k;
    k = 0;
    while ((t % FRAME) != p && k < 200) begin
      @(negedge clk);
      k++;
    end
    vecs++;
    if (k >= 200) begin
      errs++;
      $display("FAIL wait_phase: got phase=%0d, want %0d within 200 cycles", t % FRAME, p);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; wr_en = 1'b0; din = '0; dp_in = '0;
    cyc(3);
    rst_n = 1'b1; en = 1'b1;

    // First frame: 1234 with dp on digit 2, visible only after a boundary.
    cyc(2);
    write(16'h1234, 4'b0100);
    cyc(100);

    // Mid-frame write is superseded by a write in the boundary cycle.
    wait_phase(10);
    write(16'h5678, 4'b0011);
    wait_phase(FRAME - 1);
    write(16'h9999, 4'b1000);
    cyc(70);

    // Scan pause: held counter/index, frame_done shifted.
    wait_phase(13);
    en = 1'b0;
    cyc(20);
    en = 1'b1;
    cyc(80);

    // Zero and dark-code patterns.
    write(16'h0070, 4'b0000);
    cyc(70);
    write(16'hA000, 4'b0001);
    cyc(70);
    write(16'h0000, 4'b1010);
    cyc(70);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      en    = ($urandom % 8) != 0;
      wr_en = ($urandom % 10) == 0;
      din   = 16'($urandom);
      dp_in = 4'($urandom);
      @(negedge clk);
    end
    en = 1'b1; wr_en = 1'b0;
    write(16'h4321, 4'b0010);
    cyc(70);

    // Asynchronous reset in the middle of digit 2's slot.
    wait_phase(2 * DIV + 4);
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if (an !== 4'b1111 || seg !== 8'h00 || frame_done !== 1'b0) begin
      errs++;
      $display("FAIL async_reset: got seg=%h an=%b fd=%b, want seg=00 an=1111 fd=0",
               seg, an, frame_done);
    end
    cyc(3);
    rst_n = 1'b1;
    cyc(80);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
